// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : led_pattern_gen
//  Description : Prescaled LED / analyzer pattern source with a debounced
//                mode button (up, down, single-bit scan, hold).
//  Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_gen #(
   parameter int CNT_W        = 8,
   parameter int PRESCALE     = 13_500_000,
   parameter int DEBOUNCE_CYC = 270_000
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             btn_n,
   input  logic             en,
   output logic [CNT_W-1:0] counter,
   output logic             trig,
   output logic             tick,
   output logic [1:0]       mode,
   output logic             led_n
);

   localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int DB_W  = $clog2(DEBOUNCE_CYC + 1);

   localparam logic [PRE_W-1:0] C_PRE_LAST = PRE_W'(PRESCALE - 1);
   localparam logic [DB_W-1:0]  C_DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);

   localparam logic [1:0] ST_UP   = 2'd0;
   localparam logic [1:0] ST_DOWN = 2'd1;
   localparam logic [1:0] ST_SCAN = 2'd2;
   localparam logic [1:0] ST_HOLD = 2'd3;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   logic [PRE_W-1:0] pre_q;
   logic             tick_q;
   logic             btn_meta_q;
   logic             btn_sync_q;
   logic             btn_acc_q;
   logic [DB_W-1:0]  db_q;
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dir_q, dir_d;
   logic             trig_q, trig_d;
   logic             led_n_q;

   logic             w_mismatch;
   logic             w_db_done;
   logic             w_btn_evt;

   // Prescaler: tick is a registered strobe one cycle after the last count
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         pre_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         tick_q <= en && (pre_q == C_PRE_LAST);
         if (en) begin
            pre_q <= (pre_q == C_PRE_LAST) ? '0 : pre_q + PRE_W'(1);
         end
      end
   end

   assign w_mismatch = (btn_sync_q != btn_acc_q);
   assign w_db_done  = w_mismatch && (db_q == C_DB_LAST);
   assign w_btn_evt  = w_db_done && !btn_sync_q;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         btn_meta_q <= 1'b1;
         btn_sync_q <= 1'b1;
         btn_acc_q  <= 1'b1;
         db_q       <= '0;
      end else begin
         btn_meta_q <= btn_n;
         btn_sync_q <= btn_meta_q;
         if (w_db_done) begin
            btn_acc_q <= btn_sync_q;
            db_q      <= '0;
         end else if (w_mismatch) begin
            db_q <= db_q + DB_W'(1);
         end else begin
            db_q <= '0;
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q <= ST_UP;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (w_btn_evt) begin
         case (state_q)
            ST_UP:   state_d = ST_DOWN;
            ST_DOWN: state_d = ST_SCAN;
            ST_SCAN: state_d = ST_HOLD;
            default: state_d = ST_UP;
         endcase
      end
   end

   // A mode change takes priority over a coincident step, which is dropped
   always_comb begin
      cnt_d  = cnt_q;
      dir_d  = dir_q;
      trig_d = 1'b0;
      if (w_btn_evt) begin
         if (state_d == ST_SCAN) begin
            cnt_d = CNT_W'(1);
            dir_d = DIR_LEFT;
         end
      end else if (tick_q) begin
         case (state_q)
            ST_UP: begin
               cnt_d  = cnt_q + CNT_W'(1);
               trig_d = (cnt_d == '0);
            end
            ST_DOWN: begin
               cnt_d  = cnt_q - CNT_W'(1);
               trig_d = &cnt_d;
            end
            ST_SCAN: begin
               if (dir_q == DIR_LEFT) begin
                  cnt_d = cnt_q << 1;
                  if (cnt_d[CNT_W-1]) begin
                     dir_d = DIR_RIGHT;
                  end
               end else begin
                  cnt_d = cnt_q >> 1;
                  if (cnt_d == CNT_W'(1)) begin
                     dir_d  = DIR_LEFT;
                     trig_d = 1'b1;
                  end
               end
            end
            default: begin
               cnt_d = cnt_q;
            end
         endcase
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         cnt_q   <= '0;
         dir_q   <= DIR_LEFT;
         trig_q  <= 1'b0;
         led_n_q <= 1'b1;
      end else begin
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         trig_q  <= trig_d;
         led_n_q <= ~cnt_d[CNT_W-1];
      end
   end

   assign counter = cnt_q;
   assign trig    = trig_q;
   assign tick    = tick_q;
   assign mode    = state_q;
   assign led_n   = led_n_q;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_pattern_gen
//  Description : Randomized scoreboard bench for led_pattern_gen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pattern_gen;

   localparam int W   = 8;
   localparam int PRE = 4;
   localparam int DEB = 8;

   typedef struct packed {
      logic [W-1:0] cnt;
      logic         trig;
      logic         tick;
      logic [1:0]   mode;
      logic         led_n;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         btn_n;
   logic         en;
   logic [W-1:0] counter;
   logic         trig;
   logic         tick;
   logic [1:0]   mode;
   logic         led_n;

   int checks = 0;
   int errors = 0;
   exp_t exp_q[$];

   // Reference model state
   bit m_s1, m_s2, m_acc, m_tick, m_trig;
   int m_db, m_pre, m_mode, m_cnt, m_pos, m_dir;

   led_pattern_gen #(
      .CNT_W       (W),
      .PRESCALE    (PRE),
      .DEBOUNCE_CYC(DEB)
   ) dut (
      .sys_clk(clk),
      .sys_rst(rst),
      .btn_n  (btn_n),
      .en     (en),
      .counter(counter),
      .trig   (trig),
      .tick   (tick),
      .mode   (mode),
      .led_n  (led_n)
   );

   always #5 clk = ~clk;

   task automatic model_step();
      exp_t e;
      bit   evt;
      bit   step;
      if (rst) begin
         m_s1 = 1; m_s2 = 1; m_acc = 1; m_db = 0;
         m_pre = 0; m_tick = 0; m_mode = 0; m_cnt = 0;
         m_pos = 0; m_dir = 0; m_trig = 0;
      end else begin
         // Accept a new level after it has differed for DEB consecutive cycles
         evt = 0;
         if (m_s2 != m_acc) begin
            m_db = m_db + 1;
            if (m_db == DEB) begin
               m_acc = m_s2;
               m_db  = 0;
               evt   = (m_acc == 0);
            end
         end else begin
            m_db = 0;
         end
         m_s2 = m_s1;
         m_s1 = btn_n;

         step   = m_tick && !evt;
         m_trig = 0;
         if (evt) begin
            m_mode = (m_mode + 1) % 4;
            if (m_mode == 2) begin
               m_pos = 0; m_dir = 0; m_cnt = 1;
            end
         end else if (step) begin
            case (m_mode)
               0: begin
                  m_cnt  = (m_cnt + 1) % (1 << W);
                  m_trig = (m_cnt == 0);
               end
               1: begin
                  m_cnt  = (m_cnt + (1 << W) - 1) % (1 << W);
                  m_trig = (m_cnt == (1 << W) - 1);
               end
               2: begin
                  if (m_dir == 0) begin
                     m_pos = m_pos + 1;
                     if (m_pos == W - 1) m_dir = 1;
                  end else begin
                     m_pos = m_pos - 1;
                     if (m_pos == 0) begin
                        m_dir = 0; m_trig = 1;
                     end
                  end
                  m_cnt = 1 << m_pos;
               end
               default: ;
            endcase
         end
         m_tick = en && (m_pre == PRE - 1);
         if (en) m_pre = (m_pre + 1) % PRE;
      end
      e.cnt   = m_cnt[W-1:0];
      e.trig  = m_trig;
      e.tick  = m_tick;
      e.mode  = m_mode[1:0];
      e.led_n = !m_cnt[W-1];
      exp_q.push_back(e);
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      exp_t e;
      exp_t got;
      @(negedge clk);
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         got = {counter, trig, tick, mode, led_n};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL outputs t=%0t got cnt=%h trig=%b tick=%b mode=%0d led_n=%b, expected cnt=%h trig=%b tick=%b mode=%0d led_n=%b",
                     $time, got.cnt, got.trig, got.tick, got.mode, got.led_n,
                     e.cnt, e.trig, e.tick, e.mode, e.led_n);
         end
      end
   end

   task automatic run(input int n);
      repeat (n) begin
         @(negedge clk);
         #2;
      end
   endtask

   task automatic press(input int lo, input int hi);
      btn_n = 1'b0;
      run(lo);
      btn_n = 1'b1;
      run(hi);
   endtask

   task automatic check_mode(input string name, input logic [1:0] want);
      checks++;
      if (mode !== want) begin
         errors++;
         $display("FAIL %s mode got %0d expected %0d", name, mode, want);
      end
   endtask

   initial begin
      rst   = 1'b1;
      btn_n = 1'b1;
      en    = 1'b1;
      run(3);
      rst = 1'b0;
      run(1100);

      repeat (4) press(5, 10);
      check_mode("glitch_reject", 2'd0);

      press(12, 20);
      check_mode("first_press", 2'd1);
      run(1100);

      press(12, 20);
      check_mode("second_press", 2'd2);
      run(80);

      press(12, 20);
      check_mode("third_press", 2'd3);
      run(40);
      press(12, 20);
      check_mode("fourth_press", 2'd0);

      for (int i = 0; i < 120; i++) begin
         en = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 14) == 0) begin
            btn_n = 1'b0;
            run($urandom_range(1, 12));
            rst = 1'b1;
            run($urandom_range(1, 3));
            rst   = 1'b0;
            btn_n = 1'b1;
            run($urandom_range(1, 10));
         end else begin
            press($urandom_range(1, 14), $urandom_range(1, 40));
         end
         if ($urandom_range(0, 3) == 0) run($urandom_range(40, 160));
      end

      en = 1'b1;
      run(20);
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain pending %0d expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
